mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage RISC-V pipeline.
- Sits between the pipeline and the memory inside TOP.
- Serialises accesses through a level handshake, gives fixed priority to MEM, and produces per-stage stall signals.
- Handles fetch flushes on taken branches and a memory-timeout bus error.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
// MEM side has fixed priority; completions grant the other side directly with no idle bubble.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_if,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_mem,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // state   | meaning
  // IDLE    | no access in flight, arbitrate dm over if
  // DM_WAIT | load/store on the memory bus
  // IF_WAIT | fetch on the memory bus
  // DM_DONE | dm_valid pulse, may grant a pending fetch
  // IF_DONE | if_valid pulse, may grant a pending load/store
  typedef enum logic [2:0] {IDLE, DM_WAIT, IF_WAIT, DM_DONE, IF_DONE} state_t;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TIMEOUT - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              discard_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [3:0]        mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_valid_q;
  logic              dm_valid_q;
  logic              bus_err_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic grant_dm_d;
  logic grant_if_d;
  logic in_wait;
  logic finish_d;
  logic drop_if_d;

  always_comb begin
    grant_dm_d = 1'b0;
    grant_if_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_dm_d = dm_req;
        grant_if_d = ~dm_req & if_req;
      end
      DM_DONE: grant_if_d = if_req;
      IF_DONE: grant_dm_d = dm_req;
      default: ;
    endcase
  end

  assign in_wait   = (state_q == DM_WAIT) | (state_q == IF_WAIT);
  // an access ends on mem_ready, or on the last allowed wait cycle without it
  assign finish_d  = in_wait & (mem_ready | (cnt_q == '0));
  assign drop_if_d = discard_q | if_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
      if (state_q == IF_DONE) discard_q <= 1'b0;

      if (grant_dm_d) begin
        state_q     <= DM_WAIT;
        mem_req_q   <= 1'b1;
        mem_we_q    <= dm_we;
        mem_be_q    <= dm_be;
        mem_addr_q  <= dm_addr;
        mem_wdata_q <= dm_wdata;
        cnt_q       <= CNT_INIT;
      end else if (grant_if_d) begin
        state_q     <= IF_WAIT;
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_be_q    <= 4'hF;
        mem_addr_q  <= if_addr;
        mem_wdata_q <= '0;
        cnt_q       <= CNT_INIT;
      end else begin
        unique case (state_q)
          DM_WAIT: begin
            if (finish_d) begin
              state_q    <= DM_DONE;
              mem_req_q  <= 1'b0;
              dm_valid_q <= 1'b1;
              bus_err_q  <= ~mem_ready;
              dm_rdata_q <= mem_ready ? mem_rdata : '0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          IF_WAIT: begin
            discard_q <= drop_if_d;
            if (finish_d) begin
              state_q    <= IF_DONE;
              mem_req_q  <= 1'b0;
              if_valid_q <= ~drop_if_d;
              bus_err_q  <= ~mem_ready & ~drop_if_d;
              if_rdata_q <= mem_ready ? mem_rdata : '0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          DM_DONE, IF_DONE: state_q <= IDLE;
          default: ;
        endcase
      end
    end
  end

  // a flush landing in the completion cycle still kills the fetch result
  assign if_valid  = if_valid_q & ~if_flush;
  assign bus_err   = bus_err_q & ~((state_q == IF_DONE) & if_flush);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign stall_mem = dm_req & ~dm_valid;
  assign stall_if  = (if_req & ~if_valid) | stall_mem;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus a randomized
// phase checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid, stall_if;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_valid, stall_mem, bus_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_rdata(if_rdata),
    .if_valid(if_valid), .stall_if(stall_if),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall_mem(stall_mem), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: which side owns the bus, how long it has waited,
  // which side is reporting completion this cycle, and the latched results.
  int          m_owner;   // 0 none, 1 load/store, 2 fetch
  int          m_waited;
  int          m_done;    // side reporting completion this cycle, 0 if none
  logic        m_err, m_disc;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  int          m_next;
  logic [31:0] m_rd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = 0; m_waited = 0; m_done = 0; m_err = 0; m_disc = 0;
      m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0;
    end else if (m_owner != 0) begin
      if (m_owner == 2 && if_flush) m_disc = 1;
      if (mem_ready || m_waited == TO - 1) begin
        m_err = !mem_ready;
        m_rd  = mem_ready ? mem_rdata : 32'h0;
        if (m_owner == 1) m_dm_rdata = m_rd; else m_if_rdata = m_rd;
        m_done  = m_owner;
        m_owner = 0;
      end else begin
        m_waited++;
      end
    end else begin
      if (m_done == 1)      m_next = if_req ? 2 : 0;
      else if (m_done == 2) m_next = dm_req ? 1 : 0;
      else                  m_next = dm_req ? 1 : (if_req ? 2 : 0);
      m_done = 0; m_err = 0; m_disc = 0;
      if (m_next == 1) begin
        m_we = dm_we; m_be = dm_be; m_addr = dm_addr; m_wdata = dm_wdata;
      end else if (m_next == 2) begin
        m_we = 0; m_be = 4'hF; m_addr = if_addr; m_wdata = 0;
      end
      m_owner  = m_next;
      m_waited = 0;
    end
  end

  function automatic logic exp_if_valid();
    return (m_done == 2) && !m_disc && !if_flush;
  endfunction

  function automatic logic exp_dm_valid();
    return m_done == 1;
  endfunction

  always @(negedge clk) begin
    #4;
    chk("mem_req", mem_req, m_owner != 0);
    chk("if_valid", if_valid, exp_if_valid());
    chk("dm_valid", dm_valid, exp_dm_valid());
    chk("bus_err", bus_err, m_err && (exp_dm_valid() || exp_if_valid()));
    chk("stall_mem", stall_mem, dm_req && !exp_dm_valid());
    chk("stall_if", stall_if, (if_req && !exp_if_valid()) || (dm_req && !exp_dm_valid()));
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("dm_rdata", dm_rdata, m_dm_rdata);
    if (m_owner != 0 || !rst) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      chk("mem_be", mem_be, m_be);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
  end

  // Memory responder: ready after a chosen number of wait cycles; garbage rdata otherwise.
  int          rsp_cnt = 0, rsp_cur = 0, rsp_lat = 0;
  bit          rsp_given = 0, rsp_rand = 0;
  logic [31:0] rsp_data = '0;

  function automatic int pick_lat();
    int r = $urandom_range(0, 15);
    if (r == 15) return 1000;
    if (r == 14) return TO - 1;
    return r % 4;
  endfunction

  always @(negedge clk) begin
    #1;
    if (mem_req && !rsp_given) begin
      if (rsp_cnt == rsp_cur) begin
        mem_ready = 1'b1;
        mem_rdata = rsp_rand ? $urandom : rsp_data;
        rsp_given = 1;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        rsp_cnt++;
      end
    end else begin
      mem_ready = rsp_rand && !mem_req && ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      if (!mem_req) begin
        rsp_given = 0;
        rsp_cnt   = 0;
        rsp_cur   = rsp_rand ? pick_lat() : rsp_lat;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    bit seen;
    repeat (3) step();
    settle();
    chk("rst mem_req", mem_req, 0);
    chk("rst if_valid", if_valid, 0);
    chk("rst dm_valid", dm_valid, 0);
    chk("rst bus_err", bus_err, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst if_rdata", if_rdata, 0);
    step();
    rst = 1'b1;

    // Fetch with zero-wait memory
    rsp_lat = 0; rsp_data = 32'h0000_0013;
    step(); if_req = 1; if_addr = 32'h10; settle();
    chk("t1 stall_if t", stall_if, 1);
    step(); settle();
    chk("t1 mem_req", mem_req, 1);
    chk("t1 mem_addr", mem_addr, 32'h10);
    chk("t1 mem_be", mem_be, 4'hF);
    chk("t1 stall_if t+1", stall_if, 1);
    step(); settle();
    chk("t1 if_valid", if_valid, 1);
    chk("t1 if_rdata", if_rdata, 32'h13);
    chk("t1 mem_req low", mem_req, 0);
    chk("t1 stall_if t+2", stall_if, 0);
    step(); if_req = 0;
    step();

    // Simultaneous store and fetch: store first, fetch granted from DM_DONE
    step();
    dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h20; rsp_data = 32'h0000_0033;
    step(); settle();
    chk("t2 mem_we", mem_we, 1);
    chk("t2 mem_be", mem_be, 4'b0011);
    chk("t2 mem_addr", mem_addr, 32'h100);
    chk("t2 mem_wdata", mem_wdata, 32'hDEADBEEF);
    step(); settle();
    chk("t2 dm_valid", dm_valid, 1);
    chk("t2 stall_if", stall_if, 1);
    step(); dm_req = 0; dm_we = 0; settle();
    chk("t2 fetch mem_req", mem_req, 1);
    chk("t2 fetch mem_addr", mem_addr, 32'h20);
    chk("t2 fetch mem_we", mem_we, 0);
    step(); settle();
    chk("t2 if_valid", if_valid, 1);
    chk("t2 if_rdata", if_rdata, 32'h33);
    step(); if_req = 0;
    step();

    // Load with three wait cycles
    rsp_lat = 3; rsp_data = 32'h1234_5678;
    step(); dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      step(); settle();
      chk("t3 mem_req", mem_req, 1);
      chk("t3 mem_addr", mem_addr, 32'h200);
      chk("t3 stall_mem", stall_mem, 1);
    end
    step(); settle();
    chk("t3 dm_valid", dm_valid, 1);
    chk("t3 dm_rdata", dm_rdata, 32'h1234_5678);
    chk("t3 stall_mem", stall_mem, 0);
    chk("t3 mem_req low", mem_req, 0);
    step(); dm_req = 0;
    step();

    // Flush during IF_WAIT discards the fetch; the new target is then served
    rsp_lat = 2; rsp_data = 32'h0000_0093;
    step(); if_req = 1; if_addr = 32'h40;
    step(); if_flush = 1; if_addr = 32'h80; settle();
    chk("t4 mem_addr", mem_addr, 32'h40);
    chk("t4 if_valid c+1", if_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step(); if_flush = 0; settle();
      chk("t4 if_valid suppressed", if_valid, 0);
    end
    step(); settle();
    chk("t4 new mem_req", mem_req, 1);
    chk("t4 new mem_addr", mem_addr, 32'h80);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(); settle();
      if (if_valid === 1'b1) seen = 1;
    end
    chk("t4 if_valid seen", seen, 1);
    chk("t4 if_rdata", if_rdata, 32'h93);
    step(); if_req = 0;
    step();

    // Timeout: memory never answers
    rsp_lat = 1000;
    step(); dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    for (int i = 0; i < TO; i++) begin
      step(); settle();
      chk("t5 mem_req waiting", mem_req, 1);
    end
    step(); settle();
    chk("t5 mem_req dropped", mem_req, 0);
    chk("t5 dm_valid", dm_valid, 1);
    chk("t5 bus_err", bus_err, 1);
    chk("t5 dm_rdata", dm_rdata, 0);
    step(); dm_req = 0; settle();
    chk("t5 idle mem_req", mem_req, 0);
    chk("t5 idle bus_err", bus_err, 0);
    step();

    // Asynchronous reset in the middle of DM_WAIT
    step(); dm_req = 1; dm_addr = 32'h400;
    step(); settle();
    chk("t6 mem_req before rst", mem_req, 1);
    rst = 0;
    settle();
    chk("t6 mem_req async drop", mem_req, 0);
    chk("t6 stall_mem in rst", stall_mem, 1);
    rsp_lat = 0; rsp_data = 32'hCAFE_0001;
    step(); step();
    rst = 1;
    step(); settle();
    chk("t6 regrant mem_req", mem_req, 1);
    chk("t6 regrant mem_addr", mem_addr, 32'h400);
    step(); settle();
    chk("t6 dm_valid", dm_valid, 1);
    chk("t6 dm_rdata", dm_rdata, 32'hCAFE_0001);
    step(); dm_req = 0;
    step(); step();

    // Randomized traffic against the model
    rsp_rand = 1;
    repeat (3000) begin
      step();
      if_flush = 0;
      if (if_req && $urandom_range(0, 15) == 0) begin
        if_flush = 1;
        if_addr  = $urandom & 32'hFFFF_FFFC;
      end else if (m_done == 2 && !m_disc) begin
        if_addr = if_addr + 4;
        if_req  = ($urandom_range(0, 3) != 0);
      end else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req  = 1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if ((m_done == 1) || (!dm_req && $urandom_range(0, 4) == 0)) begin
        dm_req   = (m_done == 1) ? ($urandom_range(0, 2) == 0) : 1'b1;
        dm_we    = $urandom_range(0, 1);
        dm_be    = $urandom_range(0, 15);
        dm_addr  = $urandom & 32'hFFFF_FFFC;
        dm_wdata = $urandom;
      end
    end
    if_req = 0; dm_req = 0; if_flush = 0;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
